// File: rtl/systolic_ws_sched.sv
// Weight-stationary tile sequencer: loads each weight tile, fires one array pass, waits for drain.
// Optional SYSTOLIC_WS_SCHED_PERF_EN adds busy/stall cycle counters.
module systolic_ws_sched #(
  parameter int DATA_WIDTH        = 8,
  parameter int COL_NUM           = 8,
  parameter int LENGTH            = 8,
  parameter int TILE_W            = 8,
  parameter int W_ADDR_WIDTH      = 16,
  parameter int LENGTH_ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TILE_W-1:0]            k_tiles,
  input  logic [TILE_W-1:0]            n_tiles,
  output logic                         rdy,
  output logic                         busy,
  output logic                         done,
  output logic                         w_rd_en,
  output logic [W_ADDR_WIDTH-1:0]      w_rdaddr,
  output logic                         w_ld_en,
  output logic [LENGTH_ADDR_WIDTH-1:0] w_ld_row,
  output logic                         arr_val_in,
  input  logic                         arr_rdy_in,
  output logic                         acc_en,
  output logic [TILE_W-1:0]            tile_k_idx,
  output logic [TILE_W-1:0]            tile_n_idx,
`ifdef SYSTOLIC_WS_SCHED_PERF_EN
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_stall,
`endif
  output logic [2:0]                   dbg_state
);

  // Array handshake: a pass is requested while arr_val_in=1 and is taken in the
  // cycle where arr_rdy_in=1 as well; afterwards arr_rdy_in=1 in WAIT means drained.

  if (DATA_WIDTH < 1 || COL_NUM < 1 || LENGTH < 2) begin : g_bad_params
    $error("systolic_ws_sched: invalid tile geometry");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    FIRE  = 3'd3,
    GAP   = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [LENGTH_ADDR_WIDTH-1:0] LastRow = LENGTH_ADDR_WIDTH'(LENGTH - 1);

  state_t                         state_q, state_d;
  logic [TILE_W-1:0]              k_cnt_q, k_cnt_d;
  logic [TILE_W-1:0]              n_cnt_q, n_cnt_d;
  logic [TILE_W-1:0]              k_idx_q, k_idx_d;
  logic [TILE_W-1:0]              n_idx_q, n_idx_d;
  logic [LENGTH_ADDR_WIDTH-1:0]   row_q, row_d;
  logic                           ld_en_q;
  logic [LENGTH_ADDR_WIDTH-1:0]   ld_row_q;
  logic [31:0]                    addr_lin;

  always_comb begin
    state_d = state_q;
    k_cnt_d = k_cnt_q;
    n_cnt_d = n_cnt_q;
    k_idx_d = k_idx_q;
    n_idx_d = n_idx_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_cnt_d = k_tiles;
          n_cnt_d = n_tiles;
          k_idx_d = '0;
          n_idx_d = '0;
          state_d = (k_tiles == '0 || n_tiles == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (row_q == LastRow) begin
          row_d   = '0;
          state_d = FLUSH;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      FLUSH: state_d = FIRE;
      FIRE:  if (arr_rdy_in) state_d = GAP;
      GAP:   state_d = WAIT;
      WAIT: begin
        // k is the inner loop, n the outer loop
        if (arr_rdy_in) begin
          if (k_idx_q < k_cnt_q - 1'b1) begin
            k_idx_d = k_idx_q + 1'b1;
            state_d = LOAD;
          end else if (n_idx_q < n_cnt_q - 1'b1) begin
            k_idx_d = '0;
            n_idx_d = n_idx_q + 1'b1;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_cnt_q  <= '0;
      n_cnt_q  <= '0;
      k_idx_q  <= '0;
      n_idx_q  <= '0;
      row_q    <= '0;
      ld_en_q  <= 1'b0;
      ld_row_q <= '0;
    end else begin
      state_q  <= state_d;
      k_cnt_q  <= k_cnt_d;
      n_cnt_q  <= n_cnt_d;
      k_idx_q  <= k_idx_d;
      n_idx_q  <= n_idx_d;
      row_q    <= row_d;
      ld_en_q  <= (state_q == LOAD);
      ld_row_q <= row_q;
    end
  end

  // Tiles are laid out n-major, k-minor, one SRAM word per tile row
  assign addr_lin = (32'(n_idx_q) * 32'(k_cnt_q) + 32'(k_idx_q)) * 32'(LENGTH) + 32'(row_q);

  assign rdy        = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign w_rd_en    = (state_q == LOAD);
  assign w_rdaddr   = (state_q == LOAD) ? W_ADDR_WIDTH'(addr_lin) : '0;
  assign w_ld_en    = ld_en_q;
  assign w_ld_row   = ld_row_q;
  assign arr_val_in = (state_q == FIRE);
  assign acc_en     = (state_q == FIRE || state_q == GAP || state_q == WAIT) && (k_idx_q != '0);
  assign tile_k_idx = k_idx_q;
  assign tile_n_idx = n_idx_q;
  assign dbg_state  = state_q;

`ifdef SYSTOLIC_WS_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == IDLE && start) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 1'b1;
      if (((state_q == FIRE && !arr_rdy_in) || state_q == WAIT) && perf_stall_q != '1)
        perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_ws_sched.sv
// Scoreboard bench for systolic_ws_sched: expected SRAM addresses, load rows and pass
// tags are queued per job and popped as the DUT produces them; job timing is modelled.
module tb_systolic_ws_sched;

  localparam int LENGTH = 8;
  localparam int TILE_W = 8;
  localparam int AW     = 16;
  localparam int LAW    = $clog2(LENGTH);

  localparam logic [2:0] S_FIRE = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [TILE_W-1:0] k_tiles, n_tiles;
  logic              rdy, busy, done, w_rd_en, w_ld_en, arr_val_in, arr_rdy_in, acc_en;
  logic [AW-1:0]     w_rdaddr;
  logic [LAW-1:0]    w_ld_row;
  logic [TILE_W-1:0] tile_k_idx, tile_n_idx;
  logic [2:0]        dbg_state;
`ifdef SYSTOLIC_WS_SCHED_PERF_EN
  logic [31:0]       perf_cycles, perf_stall;
`endif

  systolic_ws_sched #(
    .DATA_WIDTH(8), .COL_NUM(8), .LENGTH(LENGTH), .TILE_W(TILE_W), .W_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_tiles(k_tiles), .n_tiles(n_tiles),
    .rdy(rdy), .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rdaddr(w_rdaddr),
    .w_ld_en(w_ld_en), .w_ld_row(w_ld_row), .arr_val_in(arr_val_in), .arr_rdy_in(arr_rdy_in),
    .acc_en(acc_en), .tile_k_idx(tile_k_idx), .tile_n_idx(tile_n_idx),
`ifdef SYSTOLIC_WS_SCHED_PERF_EN
    .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [AW-1:0]       exp_addr_q[$];
  logic [LAW-1:0]      exp_row_q[$];
  logic [2*TILE_W:0]   exp_fire_q[$];

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  int   fire_stall = 0;
  int   wait_lat   = 0;
  int   t_acc, t_rd, t_val, t_done;
  int   rd_cnt = 0, val_cnt = 0, done_cnt = 0;
  bit   rd_seen, val_seen;
  logic prev_reset = 1'b0;
  logic prev_rd_en = 1'b0;

  always @(negedge clk) begin
    if (reset && prev_reset) begin
      if (start && rdy) begin
        t_acc    = cyc;
        rd_seen  = 1'b0;
        val_seen = 1'b0;
      end
      if (w_rd_en) begin
        rd_cnt++;
        if (!rd_seen) begin rd_seen = 1'b1; t_rd = cyc; end
        check("acc_en_in_load", 32'(acc_en), 32'd0);
        if (exp_addr_q.size() == 0) check("rdaddr_unexpected", 32'(w_rdaddr), 32'hFFFF_FFFF);
        else check("rdaddr", 32'(w_rdaddr), 32'(exp_addr_q.pop_front()));
      end
      if (w_ld_en || prev_rd_en) check("ld_en_lag", 32'(w_ld_en), 32'(prev_rd_en));
      if (w_ld_en) begin
        if (exp_row_q.size() == 0) check("ld_row_unexpected", 32'(w_ld_row), 32'hFFFF_FFFF);
        else check("ld_row", 32'(w_ld_row), 32'(exp_row_q.pop_front()));
      end
      if (arr_val_in) begin
        val_cnt++;
        if (!val_seen) begin val_seen = 1'b1; t_val = cyc; end
        if (arr_rdy_in) begin
          if (exp_fire_q.size() == 0) check("pass_unexpected", 32'(tile_k_idx), 32'hFFFF_FFFF);
          else begin
            logic [2*TILE_W:0] e;
            e = exp_fire_q.pop_front();
            check("tile_n_idx", 32'(tile_n_idx), 32'(e[2*TILE_W:TILE_W+1]));
            check("tile_k_idx", 32'(tile_k_idx), 32'(e[TILE_W:1]));
            check("acc_en", 32'(acc_en), 32'(e[0]));
          end
        end
      end
      if (done) begin
        done_cnt++;
        t_done = cyc;
      end
    end
    prev_reset = reset;
    prev_rd_en = w_rd_en;
  end

  // ---------------- array responder ----------------
  int cnt_f = 0, cnt_w = 0;
  initial begin
    arr_rdy_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dbg_state == S_FIRE) begin arr_rdy_in = (cnt_f >= fire_stall); cnt_f++; end
      else cnt_f = 0;
      if (dbg_state == S_WAIT) begin arr_rdy_in = (cnt_w >= wait_lat); cnt_w++; end
      else cnt_w = 0;
      if (dbg_state != S_FIRE && dbg_state != S_WAIT) arr_rdy_in = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_job(input int k, input int n);
    for (int ni = 0; ni < n; ni++)
      for (int ki = 0; ki < k; ki++) begin
        for (int r = 0; r < LENGTH; r++) begin
          exp_addr_q.push_back(AW'((ni * k + ki) * LENGTH + r));
          exp_row_q.push_back(LAW'(r));
        end
        exp_fire_q.push_back({TILE_W'(ni), TILE_W'(ki), ki != 0});
      end
  endtask

  task automatic check_idle();
    check("idle_rdy", 32'(rdy), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_rd_en", 32'(w_rd_en), 32'd0);
    check("idle_rdaddr", 32'(w_rdaddr), 32'd0);
    check("idle_ld_en", 32'(w_ld_en), 32'd0);
    check("idle_ld_row", 32'(w_ld_row), 32'd0);
    check("idle_val_in", 32'(arr_val_in), 32'd0);
    check("idle_acc_en", 32'(acc_en), 32'd0);
    check("idle_k_idx", 32'(tile_k_idx), 32'd0);
    check("idle_n_idx", 32'(tile_n_idx), 32'd0);
  endtask

  task automatic run_job(input int k, input int n, input int stall, input int wlat,
                         input bit spurious);
    int tiles, d0, r0, v0, exp_done;
    bit finished;
    for (int i = 0; i < 200 && !rdy; i++) step();
    fire_stall = stall;
    wait_lat   = wlat;
    tiles = (k == 0 || n == 0) ? 0 : k * n;
    push_job(k, n);
    d0 = done_cnt; r0 = rd_cnt; v0 = val_cnt;
    start = 1'b1; k_tiles = TILE_W'(k); n_tiles = TILE_W'(n);
    step();
    start = 1'b0; k_tiles = TILE_W'($urandom); n_tiles = TILE_W'($urandom);
    finished = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (rdy) begin finished = 1'b1; break; end
      if (spurious) begin
        start = 1'($urandom_range(0, 1));
        k_tiles = TILE_W'($urandom_range(1, 4)); n_tiles = TILE_W'($urandom_range(1, 4));
      end
      step();
    end
    start = 1'b0;
    check("job_finished", 32'(finished), 32'd1);
    exp_done = t_acc + 1 + tiles * (LENGTH + 4 + stall + wlat);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("done_cycle", 32'(t_done), 32'(exp_done));
    check("rdy_after_done", 32'(cyc), 32'(t_done + 1));
    check("rd_beats", 32'(rd_cnt - r0), 32'(tiles * LENGTH));
    check("val_cycles", 32'(val_cnt - v0), 32'(tiles * (stall + 1)));
    if (tiles > 0) begin
      check("first_rd_cycle", 32'(t_rd), 32'(t_acc + 1));
      check("first_val_cycle", 32'(t_val), 32'(t_acc + LENGTH + 2));
    end
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("row_q_drained", 32'(exp_row_q.size()), 32'd0);
    check("fire_q_drained", 32'(exp_fire_q.size()), 32'd0);
`ifdef SYSTOLIC_WS_SCHED_PERF_EN
    check("perf_cycles", perf_cycles, 32'(exp_done - t_acc));
    check("perf_stall", perf_stall, 32'(tiles * (stall + wlat + 1)));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; k_tiles = '0; n_tiles = '0;
    repeat (3) step();
    check_idle();
    reset = 1'b1;
    step();

    // abort a 2x2 job in the middle of its first weight load
    push_job(2, 2);
    d0 = done_cnt;
    start = 1'b1; k_tiles = 8'd2; n_tiles = 8'd2;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_idle();
    exp_addr_q.delete(); exp_row_q.delete(); exp_fire_q.delete();
    repeat (5) step();
    check("no_done_after_abort", 32'(done_cnt), 32'(d0));

    run_job(1, 1, 0, 0, 1'b0);
    run_job(3, 2, 1, 2, 1'b0);
    run_job(0, 5, 0, 0, 1'b0);
    run_job(4, 0, 0, 0, 1'b0);
    run_job(1, 1, 20, 3, 1'b1);
    run_job(1, 1, 5, 11, 1'b0);
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
